// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and line geometry for the data memory model
package mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  localparam int LINE_BITS        = 256;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int INDEX_BITS       = 9;
  localparam int DEF_LATENCY      = 10;
endpackage

// File: rtl/data_memory.sv
// data_memory: fixed-latency line memory; clk_i/rst_i, addr_i/data_i/enable_i/write_i request in, ack_o/data_o one-cycle response out
module data_memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = LINE_BITS,
  parameter int DEPTH      = 1 << INDEX_BITS,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam int HI = LINE_OFFSET_BITS + INDEX_BITS;
  if (LATENCY < 2) begin : g_lat_chk
    $error("data_memory: LATENCY must be at least 2");
  end
  logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done;
  logic                  unused_addr;
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:HI], addr_i[LINE_OFFSET_BITS-1:0]};
  assign ack_o  = ack_q;
  assign data_o = data_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    data_d  = data_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (enable_i) begin
        idx_d   = addr_i[HI-1:LINE_OFFSET_BITS];
        wr_d    = write_i;
        wdata_d = data_i;
        cnt_d   = CW'(1);
        state_d = BUSY;
      end
      BUSY: begin
        done    = cnt_q == CW'(LATENCY);
        cnt_d   = done ? '0 : cnt_q + CW'(1);
        ack_d   = done;
        data_d  = done ? (wr_q ? wdata_q : memory[idx_q]) : data_q;
        state_d = done ? ACK : BUSY;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (done && wr_q) memory[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory
module tb_data_memory;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  addr_i = '0;
  logic [255:0] data_i = '0;
  logic         enable_i = 1'b0;
  logic         write_i = 1'b0;
  logic         ack_o;
  logic [255:0] data_o;
  int           total = 0;
  int           bad = 0;
  int           lat;
  logic [255:0] got;
  localparam logic [255:0] PAT  = {8{32'hDEADBEEF}};
  localparam logic [255:0] VC   = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] VA   = {16{16'hA5A5}};
  localparam logic [255:0] VD   = {32{8'h3C}};

  data_memory dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
    .enable_i(enable_i), .write_i(write_i), .ack_o(ack_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge e=0 is the acceptance edge; at edge mod_at the request inputs are scrambled.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [255:0] d,
                         input int mod_at, output int l, output logic [255:0] g);
    @(negedge clk_i);
    addr_i = a; write_i = w; data_i = d; enable_i = 1'b1;
    l = -1; g = '0;
    for (int e = 0; e < 40 && l < 0; e++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (e == mod_at) begin addr_i = 32'h40; data_i = ~d; write_i = ~w; end
      if (ack_o) begin l = e; g = data_o; end
    end
    enable_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("ack_one_cycle", {255'd0, ack_o}, 256'd0);
  endtask

  initial begin
    int acks [3];
    int n;
    logic prev, dbl;
    dut.memory[0]  = 256'h5;
    dut.memory[1]  = '0;
    dut.memory[2]  = VC;
    dut.memory[32] = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_ack", {255'd0, ack_o}, 256'd0);
    chk("reset_data", data_o, 256'd0);
    rst_i = 1'b0;

    run_txn(32'h0, 1'b0, '0, -1, lat, got);
    chk("read0_lat", 256'(lat), 256'd10);
    chk("read0_data", got, 256'h5);

    run_txn(32'h400, 1'b1, PAT, -1, lat, got);
    chk("write_lat", 256'(lat), 256'd10);
    chk("write_data_o", got, PAT);
    chk("write_mem32", dut.memory[32], PAT);
    run_txn(32'h400, 1'b0, '0, -1, lat, got);
    chk("readback_400", got, PAT);

    run_txn(32'h41F, 1'b0, '0, -1, lat, got);
    chk("offset_41f", got, PAT);
    run_txn(32'h4400, 1'b0, '0, -1, lat, got);
    chk("alias_4400", got, PAT);

    run_txn(32'h20, 1'b1, VA, 3, lat, got);
    chk("busy_chg_lat", 256'(lat), 256'd10);
    chk("busy_chg_mem1", dut.memory[1], VA);
    chk("busy_chg_mem2", dut.memory[2], VC);

    @(negedge clk_i);
    addr_i = 32'h40; write_i = 1'b1; data_i = VD; enable_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_ack", {255'd0, ack_o}, 256'd0);
    chk("rst_data", data_o, 256'd0);
    enable_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (15) @(negedge clk_i);
    chk("rst_mem2", dut.memory[2], VC);
    run_txn(32'h40, 1'b0, '0, -1, lat, got);
    chk("post_rst_lat", 256'(lat), 256'd10);
    chk("post_rst_data", got, VC);

    @(negedge clk_i);
    addr_i = 32'h400; write_i = 1'b0; enable_i = 1'b1;
    n = 0; prev = 1'b0; dbl = 1'b0;
    acks = '{-1, -1, -1};
    for (int e = 0; e < 40; e++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (ack_o && prev) dbl = 1'b1;
      if (ack_o && n < 3) acks[n] = e;
      if (ack_o) n++;
      prev = ack_o;
    end
    enable_i = 1'b0;
    chk("b2b_count", 256'(n), 256'd3);
    chk("b2b_ack0", 256'(acks[0]), 256'd10);
    chk("b2b_ack1", 256'(acks[1]), 256'd22);
    chk("b2b_ack2", 256'(acks[2]), 256'd34);
    chk("b2b_no_double", {255'd0, dbl}, 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
